// File: rtl/wav_sample_player.sv
// wav_sample_player: CPU-fed 8-bit PCM sample FIFO with a programmable
// sample-rate divider that pops one byte per tick onto a steady channel.
module wav_sample_player #(
  parameter int         CLK_FREQ  = 28000000,
  parameter int         ADDR_W    = 9,
  parameter logic [7:0] DATA_PORT = 8'hB3,
  parameter logic [7:0] CTRL_PORT = 8'hB7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic [7:0] sample_out,
  output logic       sample_tick
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV0  = CLK_FREQ / 8000;
  localparam int DIV1  = CLK_FREQ / 11025;
  localparam int DIV2  = CLK_FREQ / 22050;
  localparam int DIV3  = CLK_FREQ / 44100;
  localparam int CNT_W = $clog2(DIV0);

  // Reload value (divisor - 1) for a given rate code.
  function automatic logic [CNT_W-1:0] div_m1(input logic [1:0] rate);
    case (rate)
      2'd0:    div_m1 = CNT_W'(DIV0 - 1);
      2'd1:    div_m1 = CNT_W'(DIV1 - 1);
      2'd2:    div_m1 = CNT_W'(DIV2 - 1);
      default: div_m1 = CNT_W'(DIV3 - 1);
    endcase
  endfunction

  logic [7:0]       r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]  w_level;
  logic             w_full, w_empty, w_half;
  logic             r_enable;
  logic [1:0]       r_rate;
  logic             r_overrun, r_underrun;
  logic [7:0]       r_sample;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_dwr_q, r_cwr_q, r_crd_q, r_rdclr;
  logic             w_dwr_acc, w_cwr_acc, w_crd_acc;
  logic             w_dwr_edge, w_cwr_edge, w_crd_edge;
  logic             w_flush, w_pop, w_push, w_ovr_set, w_unr_set;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (ADDR_W+1)'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_half  = (w_level >= (ADDR_W+1)'(DEPTH / 2));

  assign w_dwr_acc = (a == DATA_PORT) && !iorq_n && !wr_n;
  assign w_cwr_acc = (a == CTRL_PORT) && !iorq_n && !wr_n;
  assign w_crd_acc = (a == CTRL_PORT) && !iorq_n && !rd_n;

  assign w_dwr_edge = w_dwr_acc && !r_dwr_q;
  assign w_cwr_edge = w_cwr_acc && !r_cwr_q;
  assign w_crd_edge = w_crd_acc && !r_crd_q;

  // Flush beats both a same-clk pop and a same-clk push.
  assign w_flush   = w_cwr_edge && din[6];
  assign w_pop     = r_tick && r_enable && !w_empty && !w_flush;
  assign w_push    = w_dwr_edge && !w_flush && (!w_full || w_pop);
  assign w_ovr_set = w_dwr_edge && !w_flush && w_full && !w_pop;
  assign w_unr_set = r_tick && r_enable && w_empty;

  assign dout        = {w_full, w_empty, w_half, r_overrun, r_underrun, r_enable, r_rate};
  assign oe_n        = !w_crd_acc;
  assign sample_out  = r_sample;
  assign sample_tick = r_tick;

  // Access edge detectors and the delayed read-clear strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dwr_q <= 1'b0;
      r_cwr_q <= 1'b0;
      r_crd_q <= 1'b0;
      r_rdclr <= 1'b0;
    end else begin
      r_dwr_q <= w_dwr_acc;
      r_cwr_q <= w_cwr_acc;
      r_crd_q <= w_crd_acc;
      r_rdclr <= w_crd_edge;
    end
  end

  // Control register: enable and rate; flush is a strobe and is not kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_rate   <= 2'd0;
    end else if (w_cwr_edge) begin
      r_enable <= din[7];
      r_rate   <= din[1:0];
    end
  end

  // Rate divider: counts divisor-1 down to 0, then reloads and ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_cwr_edge) begin
      r_cnt  <= din[7] ? div_m1(din[1:0]) : '0;
      r_tick <= 1'b0;
    end else if (!r_enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt  <= div_m1(r_rate);
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt - 1'b1;
      r_tick <= 1'b0;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
  end

  // Output sample: midscale while disabled, popped byte one clk after tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_sample <= 8'd128;
    else if (!r_enable) r_sample <= 8'd128;
    else if (w_pop)    r_sample <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  // Sticky flags: read-clear first, new events override it, control write last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (r_rdclr) begin
        r_overrun  <= 1'b0;
        r_underrun <= 1'b0;
      end
      if (w_unr_set) r_underrun <= 1'b1;
      if (w_ovr_set) r_overrun  <= 1'b1;
      if (w_cwr_edge) r_overrun <= 1'b0;
      if (w_flush)   r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wav_sample_player.sv
// Bench for wav_sample_player: queue-based reference model checked every clk,
// a control/status vector table, directed corner sequences and random traffic.
module tb_wav_sample_player;

  localparam logic [7:0] DP = 8'hB3;
  localparam logic [7:0] CP = 8'hB7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a = 8'h00;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe_n;
  logic [7:0] sample_out;
  logic       sample_tick;

  wav_sample_player #(
    .CLK_FREQ (28000000),
    .ADDR_W   (9),
    .DATA_PORT(8'hB3),
    .CTRL_PORT(8'hB7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .din        (din),
    .dout       (dout),
    .oe_n       (oe_n),
    .sample_out (sample_out),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  bit         m_en, m_ov, m_un, m_rdclr;
  bit [1:0]   m_rate;
  logic [7:0] m_smp;
  bit         m_pd, m_pcw, m_pcr;
  longint     m_cyc = 0;
  longint     m_next = 0;

  function automatic int div_of(input bit [1:0] r);
    case (r)
      2'd0:    return 28000000 / 8000;
      2'd1:    return 28000000 / 11025;
      2'd2:    return 28000000 / 22050;
      default: return 28000000 / 44100;
    endcase
  endfunction

  function automatic bit m_tick();
    return m_en && (m_cyc == m_next);
  endfunction

  function automatic logic [7:0] m_dout();
    int lv;
    lv = mq.size();
    return {lv == 512, lv == 0, lv >= 256, m_ov, m_un, m_en, m_rate};
  endfunction

  bit dacc, cwacc, cracc, dwr, cwr, crd, flush, tk, emp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_en = 0; m_rate = 0; m_ov = 0; m_un = 0; m_rdclr = 0;
      m_smp = 8'd128; m_pd = 0; m_pcw = 0; m_pcr = 0;
    end else begin
      dacc  = (a == DP) && !iorq_n && !wr_n;
      cwacc = (a == CP) && !iorq_n && !wr_n;
      cracc = (a == CP) && !iorq_n && !rd_n;
      dwr = dacc && !m_pd;  cwr = cwacc && !m_pcw;  crd = cracc && !m_pcr;
      m_pd = dacc; m_pcw = cwacc; m_pcr = cracc;
      flush = cwr && din[6];
      tk  = m_tick();
      emp = (mq.size() == 0);
      if (m_rdclr) begin m_ov = 0; m_un = 0; end
      if (!m_en) m_smp = 8'd128;
      if (tk && emp) m_un = 1;
      if (tk && !emp && !flush) begin
        if (m_en) m_smp = mq[0];
        void'(mq.pop_front());
      end
      if (dwr && !flush) begin
        if (mq.size() < 512) mq.push_back(din);
        else m_ov = 1;
      end
      if (cwr) begin
        m_ov = 0;
        if (flush) begin mq.delete(); m_un = 0; end
        m_en = din[7];
        m_rate = din[1:0];
        if (din[7]) m_next = m_cyc + 1 + div_of(din[1:0]);
      end else if (tk) begin
        m_next = m_next + div_of(m_rate);
      end
      m_rdclr = crd;
      m_cyc++;
    end
  end

  // Every clk: outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_tick",   sample_tick, m_tick());
      chk("m_sample", sample_out,  m_smp);
      chk("m_status", dout,        m_dout());
      chk("m_oe_n",   oe_n,        !((a == CP) && !iorq_n && !rd_n));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic io_wr(input logic [7:0] port, input logic [7:0] data, input int hold = 2);
    @(posedge clk); #1;
    a = port; din = data; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1; iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic io_rd(output logic [7:0] v, output logic oe);
    @(posedge clk); #1;
    a = CP; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    v = dout; oe = oe_n;
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    bit ok;
    n = 0; ok = 0;
    while (n < maxc && !ok) begin
      @(negedge clk);
      n++;
      ok = sample_tick;
    end
    chk("tick_seen", ok, 1);
  endtask

  typedef struct { logic [7:0] ctrl; logic [7:0] exp; } vec_t;
  vec_t tbl[6];

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    logic       oe;
    int         n;
    int         cnt;

    tbl[0] = '{8'h83, 8'h47};
    tbl[1] = '{8'h00, 8'h40};
    tbl[2] = '{8'h81, 8'h45};
    tbl[3] = '{8'h7E, 8'h42};
    tbl[4] = '{8'h82, 8'h46};
    tbl[5] = '{8'h01, 8'h41};

    #1 reset = 1'b1; chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    io_rd(v, oe);
    chk("rst_status", v, 8'h40);
    chk("rst_oe_n", oe, 0);
    chk("rst_sample", sample_out, 8'd128);

    // Two-byte playback at 44100 Hz, then underrun.
    io_wr(CP, 8'h83);
    io_wr(DP, 8'h10);
    io_wr(DP, 8'hF0);
    wait_tick(2000, n);
    chk("t1_before", sample_out, 8'd128);
    @(negedge clk); chk("t1_after", sample_out, 8'h10);
    wait_tick(2000, n); chk("period_a", n + 1, 634);
    @(negedge clk); chk("t2_after", sample_out, 8'hF0);
    wait_tick(2000, n); chk("period_b", n + 1, 634);
    @(negedge clk); chk("t3_hold", sample_out, 8'hF0);
    io_rd(v, oe); chk("underrun_status", v, 8'h4F);

    // Overfill while disabled.
    io_wr(CP, 8'h40);
    for (int i = 0; i < 513; i++) io_wr(DP, 8'(i));
    io_rd(v, oe); chk("overrun_status", v, 8'hB0);
    io_rd(v, oe); chk("overrun_cleared", v, 8'hA0);

    // Long-held write pushes once.
    io_wr(CP, 8'h40);
    io_wr(DP, 8'h5A, 10);
    io_rd(v, oe); chk("one_push", v, 8'h00);

    // Push aligned with a pop while full.
    io_wr(CP, 8'h40);
    for (int i = 0; i < 512; i++) io_wr(DP, 8'(i));
    io_rd(v, oe); chk("full_status", v, 8'hA0);
    io_wr(CP, 8'h83);
    wait_tick(2000, n);
    #1; a = DP; din = 8'hAA; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk); chk("aligned_pop", sample_out, 8'h00);
    @(posedge clk); #1; iorq_n = 1'b1; wr_n = 1'b1;
    io_rd(v, oe); chk("aligned_status", v, 8'hA7);

    // Flush mid-playback, then disable.
    wait_tick(2000, n);
    io_wr(CP, 8'hC0);
    io_rd(v, oe); chk("flush_status", v, 8'h44);
    io_wr(CP, 8'h00);
    repeat (3) @(negedge clk);
    chk("disabled_sample", sample_out, 8'd128);
    cnt = 0;
    repeat (4000) begin @(negedge clk); if (sample_tick) cnt++; end
    chk("no_ticks", cnt, 0);

    // Control/status vector table.
    for (int i = 0; i < 6; i++) begin
      io_wr(CP, tbl[i].ctrl);
      io_rd(v, oe);
      chk("tbl_status", v, tbl[i].exp);
      chk("tbl_oe_n", oe, 0);
    end
    io_wr(CP, 8'h00);

    // Random traffic against the model.
    io_wr(CP, 8'h83);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) io_wr(DP, 8'($urandom), $urandom_range(1, 4));
      else if (r < 70) io_rd(v, oe);
      else if (r < 74) io_wr(CP, {1'b1, ($urandom_range(0, 3) == 0), 4'($urandom),
                                  ($urandom_range(0, 3) != 0) ? 2'd3 : 2'($urandom)});
      else repeat ($urandom_range(1, 60)) @(posedge clk);
    end

    // Asynchronous reset in the middle of playback.
    io_wr(CP, 8'h83);
    for (int i = 0; i < 4; i++) io_wr(DP, 8'(i + 1));
    wait_tick(2000, n);
    @(posedge clk); #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_status", dout, 8'h40);
    chk("midrst_sample", sample_out, 8'd128);
    chk("midrst_tick", sample_tick, 0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wav_sample_player.md
Name: wav_sample_player

Overview:
- CPU-fed sample playback engine for the WAV add-on.
- Z80 OUTs 8-bit unsigned PCM bytes into an on-chip FIFO.
- A programmable sample-rate tick pops one byte per period and presents it as a steady 8-bit channel.
- Sits directly upstream of the panner/mixer and drives its specdrum input.

Parameters:
- CLK_FREQ, 28000000, clk frequency in Hz; used to derive the rate divisors.
- ADDR_W, 9, FIFO address width; depth = 2**ADDR_W = 512 bytes.
- DATA_PORT, 8'hB3, low address byte of the sample data port (write only).
- CTRL_PORT, 8'hB7, low address byte of the control (write) / status (read) port.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a  in  8  Z80 address low byte.
- iorq_n  in  1  Z80 IORQ, active low.
- rd_n  in  1  Z80 RD, active low.
- wr_n  in  1  Z80 WR, active low.
- din  in  8  CPU data bus in.
- dout  out  8  status byte.
- oe_n  out  1  low while the CPU reads CTRL_PORT.
- sample_out  out  8  unsigned PCM sample to the mixer.
- sample_tick  out  1  one-clk pulse on each rate tick.

Behaviour:
- Reset (async): control = 0, FIFO empty, overrun = underrun = 0, sample_out = 8'd128, divider = 0, sample_tick = 0.
- Access decode: wr_acc = (a==port) & !iorq_n & !wr_n; rd_acc likewise.
- Each access acts once, on the first clk where decode is true and was false on the previous clk (edge-detect register per access type).
- Control write (CTRL_PORT):
  - bit7 = enable; bits1:0 = rate: 0=8000, 1=11025, 2=22050, 3=44100 Hz.
  - bit6 = flush, self-clearing: empties the FIFO and clears both sticky flags in that clk. It is not stored.
  - Other bits ignored.
  - Any control write also clears overrun.
- Data write (DATA_PORT): pushes din into the FIFO.
  - Full with no pop in the same clk: byte dropped, overrun set (sticky).
  - Full with a pop in the same clk: push accepted.
  - Flush in the same clk: flush wins, push dropped.
- Status read:
  - dout = {full, empty, half, overrun, underrun, enable, rate[1:0]}, combinational from current state.
  - half = level >= 2**(ADDR_W-1).
  - oe_n = 0 only while rd_acc on CTRL_PORT; otherwise 1.
  - Both sticky flags are cleared one clk after the read edge, so the CPU sees the pre-clear value.
- Divider:
  - divisor = CLK_FREQ/rate, truncated: 3500 / 2539 / 1269 / 634 at the default CLK_FREQ.
  - While enable = 1, a counter runs from divisor-1 down to 0. At 0 it reloads and sample_tick pulses for one clk.
  - Writing a new rate reloads the counter immediately.
- Tick while FIFO non-empty: pop; sample_out takes the popped byte on the following clk (1-clk latency from sample_tick).
- Tick while FIFO empty: sample_out holds its last value; underrun set (sticky).
- enable = 0:
  - counter held at 0, no ticks, sample_out forced to 8'd128 on the next clk.
  - FIFO contents retained.
  - Re-enable: first tick occurs after a full divisor period.
- FIFO:
  - Circular, read/write pointers ADDR_W+1 bits wide; wrap-around is transparent.
  - level ranges 0 to 2**ADDR_W.
  - Simultaneous push and pop leaves level unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial push or pop is completed.

Test Plan:
- Reset, then read status -> dout = 8'h40 (empty only), oe_n low during the read, sample_out = 128.
- Write ctrl 8'h83 (enable, 44100); push 8'h10, 8'hF0 -> sample_tick every 634 clks; sample_out 16 then 240 (each 1 clk after its tick); third tick sets underrun and sample_out stays 240.
- Push 513 bytes with enable = 0 -> full = 1 after 512; 513th dropped; overrun = 1 on status read; next read shows overrun = 0.
- Hold wr_n/iorq_n low 10 clks on DATA_PORT -> exactly one byte pushed (level = 1).
- Fill to 512, enable, align a push with a tick -> push accepted, level stays 512, overrun stays 0.
- Mid-playback write ctrl 8'hC0 (flush + enable) -> empty = 1, flags cleared. Then write 8'h00 -> sample_out = 128 and no further sample_tick pulses.
